// File: rtl/mips32_wb_select_if.sv
// mips32_wb_select_if: request, memory-response and write-back signals of the write-back selector
interface mips32_wb_select_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        src_sel;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic [1:0]        addr_lo;
  logic [DATA_W-1:0] alu_res;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] link_pc;
  logic [4:0]        rd_in;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_err;
  modport slave (
    input  in_valid, src_sel, ld_size, ld_signed, addr_lo, alu_res, imm, link_pc, rd_in,
           mem_rvalid, mem_rdata,
    output in_ready, wb_valid, wb_data, wb_rd, wb_err
  );
  modport master (
    output in_valid, src_sel, ld_size, ld_signed, addr_lo, alu_res, imm, link_pc, rd_in,
           mem_rvalid, mem_rdata,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_err
  );
endinterface

// File: rtl/mips32_wb_select.sv
// mips32_wb_select: registered write-back source mux with load wait/timeout FSM; WB_LOAD_EXT_EN enables sub-word load extraction and misalignment errors
module mips32_wb_select #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input logic                clk,
  input logic                reset,
  mips32_wb_select_if.slave  bus_io
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_err_q, wb_err_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              accept;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] ld_val;
  logic              misalign;
  assign bus_io.in_ready = state_q == IDLE;
  assign accept          = bus_io.in_valid & (state_q == IDLE);
  assign bus_io.wb_valid = wb_valid_q;
  assign bus_io.wb_err   = wb_err_q;
  assign bus_io.wb_data  = wb_data_q;
  assign bus_io.wb_rd    = wb_rd_q;
  assign src_val = bus_io.src_sel == 2'd0 ? bus_io.alu_res :
                   bus_io.src_sel == 2'd1 ? DATA_W'(bus_io.imm) << (DATA_W - IMM_W) :
                   bus_io.link_pc;
`ifdef WB_LOAD_EXT_EN
  logic [1:0]  size_q, size_d;
  logic [1:0]  addr_q, addr_d;
  logic        sgn_q, sgn_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  assign ld_byte  = bus_io.mem_rdata[{addr_q, 3'b000} +: 8];
  assign ld_half  = bus_io.mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ld_word  = bus_io.mem_rdata[31:0];
  assign ld_val   = size_q == 2'd0 ? (sgn_q ? DATA_W'($signed(ld_byte)) : DATA_W'(ld_byte)) :
                    size_q == 2'd1 ? (sgn_q ? DATA_W'($signed(ld_half)) : DATA_W'(ld_half)) :
                    (sgn_q ? DATA_W'($signed(ld_word)) : DATA_W'(ld_word));
  assign misalign = (size_q == 2'd1 & addr_q[0]) | (size_q[1] & addr_q != 2'd0);
`else
  assign ld_val   = bus_io.mem_rdata;
  assign misalign = 1'b0;
`endif
  // next state: accept a request in IDLE, resolve a pending load in WAIT on data or timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_err_d   = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
`ifdef WB_LOAD_EXT_EN
    size_d     = size_q;
    addr_d     = addr_q;
    sgn_d      = sgn_q;
`endif
    if (accept) begin
      rd_d = bus_io.rd_in;
`ifdef WB_LOAD_EXT_EN
      size_d = bus_io.ld_size;
      addr_d = bus_io.addr_lo;
      sgn_d  = bus_io.ld_signed;
`endif
      if (bus_io.src_sel == 2'd2) begin
        state_d = WAIT;
        cnt_d   = '0;
      end else begin
        wb_valid_d = 1'b1;
        wb_data_d  = src_val;
        wb_rd_d    = bus_io.rd_in;
      end
    end else if (state_q == WAIT) begin
      if (bus_io.mem_rvalid || cnt_q == CW'(WAIT_MAX - 1)) begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_err_d   = !bus_io.mem_rvalid || misalign;
        wb_data_d  = wb_err_d ? '0 : ld_val;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  // state and output registers, synchronously cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
`ifdef WB_LOAD_EXT_EN
      size_q     <= '0;
      addr_q     <= '0;
      sgn_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
`ifdef WB_LOAD_EXT_EN
      size_q     <= size_d;
      addr_q     <= addr_d;
      sgn_q      <= sgn_d;
`endif
    end
  end
endmodule

// File: tb/tb_mips32_wb_select.sv
// tb_mips32_wb_select: scoreboard bench for the write-back selector
module tb_mips32_wb_select;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mips32_wb_select_if #(.DATA_W(32), .IMM_W(16)) b();
  mips32_wb_select #(.DATA_W(32), .IMM_W(16), .WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus_io(b));
  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        e;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] ld_model(input logic [1:0] sz, input logic sg, input logic [1:0] a, input logic [31:0] d);
`ifdef WB_LOAD_EXT_EN
    logic [31:0] r;
    case (sz)
      2'd0: begin
        r = {24'h0, d[a*8 +: 8]};
        if (sg && r[7]) r[31:8] = '1;
      end
      2'd1: begin
        if (a[0]) return {1'b1, 32'h0};
        r = {16'h0, d[a[1]*16 +: 16]};
        if (sg && r[15]) r[31:16] = '1;
      end
      default: begin
        if (a != 2'd0) return {1'b1, 32'h0};
        r = d;
      end
    endcase
    return {1'b0, r};
`else
    return {1'b0, d};
`endif
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      if (b.wb_valid) begin
        if (sb.size() == 0) check("unexp_wb", 1, 0);
        else begin
          e = sb.pop_front();
          check("wb_data", b.wb_data, e.d);
          check("wb_rd", b.wb_rd, e.rd);
          check("wb_err", b.wb_err, e.e);
        end
      end else check("err_idle", b.wb_err, 0);
    end
  end
  task automatic nonload(input logic [1:0] src, input logic [31:0] alu, input logic [15:0] imm,
                         input logic [31:0] link, input logic [4:0] rd, input logic [31:0] exp);
    b.in_valid = 1'b1;
    b.src_sel = src;
    b.alu_res = alu;
    b.imm = imm;
    b.link_pc = link;
    b.rd_in = rd;
    sb.push_back('{d: exp, rd: rd, e: 1'b0});
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] sz, input logic sg, input logic [1:0] a, input logic [4:0] rd,
                      input logic [31:0] d, input int waits);
    logic [32:0] m;
    m = ld_model(sz, sg, a, d);
    b.in_valid = 1'b1;
    b.src_sel = 2'd2;
    b.ld_size = sz;
    b.ld_signed = sg;
    b.addr_lo = a;
    b.rd_in = rd;
    b.alu_res = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    b.ld_size = ~sz;
    b.ld_signed = ~sg;
    b.addr_lo = ~a;
    b.rd_in = ~rd;
    repeat (waits) begin
      @(negedge clk);
      check("rdy_wait", b.in_ready, 0);
      check("no_early", b.wb_valid, 0);
      @(posedge clk);
      #1;
    end
    b.mem_rvalid = 1'b1;
    b.mem_rdata = d;
    sb.push_back('{d: m[31:0], rd: rd, e: m[32]});
    @(negedge clk);
    check("rdy_wait", b.in_ready, 0);
    @(posedge clk);
    #1;
    b.mem_rvalid = 1'b0;
    b.mem_rdata = 32'h0;
    @(negedge clk);
    check("ld_pulse", b.wb_valid, 1);
    check("rdy_after", b.in_ready, 1);
  endtask
  initial begin
    logic [1:0] s;
    logic [31:0] v;
    b.in_valid = 0; b.src_sel = 0; b.ld_size = 0; b.ld_signed = 0; b.addr_lo = 0;
    b.alu_res = 0; b.imm = 0; b.link_pc = 0; b.rd_in = 0; b.mem_rvalid = 0; b.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", b.wb_valid, 0);
    check("rst_err", b.wb_err, 0);
    check("rst_data", b.wb_data, 0);
    check("rst_rd", b.wb_rd, 0);
    check("rst_ready", b.in_ready, 1);
    nonload(2'd0, 32'h12345678, 16'h1111, 32'h22222222, 5'd5, 32'h12345678);
    b.in_valid = 1'b0;
    @(negedge clk);
    check("alu_pulse", b.wb_valid, 1);
    @(negedge clk);
    check("alu_single", b.wb_valid, 0);
    check("hold_data", b.wb_data, 32'h12345678);
    nonload(2'd1, 32'h33333333, 16'hABCD, 32'h44444444, 5'd7, 32'hABCD0000);
    nonload(2'd3, 32'h55555555, 16'h6666, 32'h00400008, 5'd31, 32'h00400008);
    b.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_pulse", b.wb_valid, 1);
    load(2'd0, 1'b1, 2'd2, 5'd9, 32'h11F02233, 3);
    load(2'd0, 1'b0, 2'd2, 5'd9, 32'h11F02233, 3);
    load(2'd1, 1'b1, 2'd2, 5'd10, 32'h80011234, 0);
    load(2'd1, 1'b0, 2'd0, 5'd11, 32'h8001F234, 2);
    load(2'd1, 1'b0, 2'd1, 5'd12, 32'hCAFE0000, 1);
    load(2'd2, 1'b1, 2'd0, 5'd13, 32'h87654321, 1);
    load(2'd2, 1'b0, 2'd2, 5'd14, 32'h76543210, 0);
    load(2'd3, 1'b0, 2'd0, 5'd15, 32'hF00DF00D, 0);
    load(2'd0, 1'b0, 2'd3, 5'd3, 32'h9A000000, 1);
    b.in_valid = 1'b1; b.src_sel = 2'd2; b.ld_size = 2'd2; b.addr_lo = 2'd0; b.rd_in = 5'd20;
    sb.push_back('{d: 32'h0, rd: 5'd20, e: 1'b1});
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("to_quiet", b.wb_valid, 0);
    end
    @(negedge clk);
    check("to_pulse", b.wb_valid, 1);
    check("to_ready", b.in_ready, 1);
    load(2'd2, 1'b0, 2'd0, 5'd16, 32'h13579BDF, 14);
    b.mem_rvalid = 1'b1;
    b.mem_rdata = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      check("idle_rvalid", b.wb_valid, 0);
    end
    b.mem_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = 2'($urandom_range(0, 2));
      s = s == 2'd2 ? 2'd3 : s;
      v = $urandom;
      nonload(s, v, v[31:16], ~v, 5'(i + 1),
              s == 2'd0 ? v : s == 2'd1 ? {v[31:16], 16'h0} : ~v);
    end
    b.in_valid = 1'b0;
    @(negedge clk);
    b.in_valid = 1'b1; b.src_sel = 2'd2; b.rd_in = 5'd21;
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    b.mem_rvalid = 1'b1;
    b.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("rst2_ready", b.in_ready, 1);
    check("rst2_valid", b.wb_valid, 0);
    check("rst2_data", b.wb_data, 0);
    check("rst2_rd", b.wb_rd, 0);
    @(posedge clk);
    #1 b.mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst2_quiet", b.wb_valid, 0);
    end
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
